md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 39 +++
 rtl/md_arith.sv | 64 ++++++
 rtl/md_unit.sv | 120 ++++++++++++
 tb/tb_md_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Optional MADD/MSUB ops are enabled by defining MD_MADD_EN.
package md_pkg;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Accumulate ops (4-7) only exist when the MADD feature is built in.
  function automatic logic op_legal(input logic [2:0] op);
    return !op[2] || MADD_EN;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator working on the latched operands.
// MADD/MSUB results are produced only when MD_MADD_EN is defined.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic        w_sgn;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Even opcodes are the signed variants.
  assign w_sgn  = !op[0];
  assign w_a64  = w_sgn ? {{32{a[31]}}, a} : {32'd0, a};
  assign w_b64  = w_sgn ? {{32{b[31]}}, b} : {32'd0, b};
  // The low 64 bits of the extended product are correct for both signednesses.
  assign w_prod = w_a64 * w_b64;

  // Magnitude division keeps 0x80000000 / -1 well defined and never divides by zero.
  assign w_a_neg = w_sgn & a[31];
  assign w_b_neg = w_sgn & b[31];
  assign w_a_mag = w_a_neg ? (32'd0 - a) : a;
  assign w_b_mag = (b == 32'd0) ? 32'd1 : (w_b_neg ? (32'd0 - b) : b);
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_quot  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    {res_hi, res_lo} = {hi, lo};
    div0             = 1'b0;
    case (md_op_t'(op))
      OP_MULT, OP_MULTU: {res_hi, res_lo} = w_prod;
      OP_DIV, OP_DIVU: begin
        {res_hi, res_lo} = {w_rem, w_quot};
        div0             = (b == 32'd0);
      end
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU: {res_hi, res_lo} = {hi, lo} + w_prod;
      OP_MSUB, OP_MSUBU: {res_hi, res_lo} = {hi, lo} - w_prod;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Define MD_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU ops (4-7).
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  md_state_t   r_state;
  md_state_t   w_state_nxt;
  logic        w_launch;
  logic        w_commit;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && op_legal(op)) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: operand latches carry no reset; they are only consumed in RUN, after a launch loads them.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_op <= op;
      r_a  <= a;
      r_b  <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_launch)
        r_cnt <= is_div(op) ? CNT_W'(DIV_CYC - 1) : CNT_W'(MULT_CYC - 1);
      else if (r_state == ST_RUN && r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);

      // A launch in the same cycle drops any MTHI/MTLO strobe.
      if (w_commit) begin
        if (!w_div0) begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end else if (r_state == ST_IDLE && !w_launch) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  md_arith u_arith (
    .op     (r_op),
    .a      (r_a),
    .b      (r_b),
    .hi     (r_hi),
    .lo     (r_lo),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo),
    .div0   (w_div0)
  );

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit against a plain-arithmetic HI/LO model.
// Expectations for ops 4-7 follow MD_MADD_EN.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input int o);
`ifdef MD_MADD_EN
    return (o >= 0) && (o <= 7);
`else
    return (o >= 0) && (o <= 3);
`endif
  endfunction

  function automatic int exp_cycles(input int o);
    if (!legal(o)) return 0;
    return (o == 2 || o == 3) ? DC : MC;
  endfunction

  // Reference model: MIPS HI/LO semantics from 64-bit integer arithmetic.
  task automatic model_exec(input int o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p, acc;
    sx = $signed(x);
    sy = $signed(y);
    acc = {m_hi, m_lo};
    if (!legal(o)) return;
    case (o)
      0: begin p = sx * sy; {m_hi, m_lo} = p; end
      1: begin p = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = p; end
      2: if (y != 0) begin
           q = sx / sy; r = sx % sy;
           m_lo = q[31:0]; m_hi = r[31:0];
         end
      3: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
      4: begin p = sx * sy; {m_hi, m_lo} = acc + p; end
      5: begin p = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = acc + p; end
      6: begin p = sx * sy; {m_hi, m_lo} = acc - p; end
      7: begin p = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = acc - p; end
      default: ;
    endcase
  endtask

  // Issues one op (optionally with MTHI/MTLO strobes on the start cycle) and observes it.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit whi, input bit wlo, input logic [31:0] wd,
                        output int bcyc, output int dcnt, output bit held, output bit tmo);
    logic [31:0] h0, l0;
    int idle;
    bcyc = 0; dcnt = 0; held = 1'b1; tmo = 1'b1; idle = 0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; a = x; b = y; hi_we = whi; lo_we = wlo; wdata = wd;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) begin
        bcyc++;
        if (hi !== h0 || lo !== l0) held = 1'b0;
      end else begin
        idle++;
      end
      if (done) dcnt++;
      if (idle >= 2) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic write_hilo(input bit whi, input bit wlo, input logic [31:0] wd);
    @(negedge clk);
    hi_we = whi; lo_we = wlo; wdata = wd;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (whi) m_hi = wd;
    if (wlo) m_lo = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    reset = 1'b0;
    write_hilo(1'b1, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_clears_hilo: hi=%h lo=%h, want 0/0", hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    write_hilo(1'b1, 1'b0, 32'hA5A5_0001);
    checks++;
    if (hi !== 32'hA5A5_0001 || lo !== m_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b, want %h/%h/0", hi, lo, busy, 32'hA5A5_0001, m_lo);
    end
    write_hilo(1'b0, 1'b1, 32'h0000_5A5A);
    checks++;
    if (lo !== 32'h0000_5A5A || hi !== 32'hA5A5_0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b, want a5a50001/00005a5a/0", hi, lo, busy);
    end
  endtask

  task automatic test_mult();
    int bc, dc; bit held, tmo;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0, bc, dc, held, tmo);
    model_exec(0, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (tmo !== 1'b0 || bc !== MC || dc !== 1 || held !== 1'b1) begin
      errors++;
      $display("FAIL mult_timing: busy_cycles=%0d done=%0d held=%b timeout=%b, want %0d/1/1/0", bc, dc, held, tmo, MC);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_result: hi=%h lo=%h, want ffffffff/fffffffa", hi, lo);
    end
    for (int i = 0; i < 4; i++) begin
      logic [2:0] o; logic [31:0] x, y;
      o = (i % 2 == 0) ? 3'd0 : 3'd1; x = $urandom; y = $urandom;
      run_op(o, x, y, 1'b0, 1'b0, 32'd0, bc, dc, held, tmo);
      model_exec(int'(o), x, y);
      checks++;
      if (tmo !== 1'b0 || bc !== MC || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL mult_rand op=%0d a=%h b=%h: hi=%h lo=%h cyc=%0d, want %h/%h cyc=%0d", o, x, y, hi, lo, bc, m_hi, m_lo, MC);
      end
    end
  endtask

  task automatic test_div();
    int bc, dc; bit held, tmo;
    run_op(3'd3, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, bc, dc, held, tmo);
    model_exec(3, 32'd100, 32'd7);
    checks++;
    if (tmo !== 1'b0 || bc !== DC || dc !== 1 || held !== 1'b1) begin
      errors++;
      $display("FAIL divu_timing: busy_cycles=%0d done=%0d held=%b timeout=%b, want %0d/1/1/0", bc, dc, held, tmo, DC);
    end
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("FAIL divu_result: hi=%h lo=%h, want 2/14", hi, lo);
    end
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, bc, dc, held, tmo);
    model_exec(2, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || bc !== DC) begin
      errors++;
      $display("FAIL div_neg: hi=%h lo=%h cyc=%0d, want ffffffff/fffffffd cyc=%0d", hi, lo, bc, DC);
    end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, bc, dc, held, tmo);
    model_exec(2, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errors++;
      $display("FAIL div_overflow: hi=%h lo=%h, want 0/80000000", hi, lo);
    end
  endtask

  task automatic test_div0();
    int bc, dc; bit held, tmo;
    write_hilo(1'b1, 1'b0, 32'h1234);
    write_hilo(1'b0, 1'b1, 32'h5678);
    run_op(3'd2, 32'd77, 32'd0, 1'b0, 1'b0, 32'd0, bc, dc, held, tmo);
    model_exec(2, 32'd77, 32'd0);
    checks++;
    if (tmo !== 1'b0 || bc !== DC || dc !== 1) begin
      errors++;
      $display("FAIL div0_timing: busy_cycles=%0d done=%0d timeout=%b, want %0d/1/0", bc, dc, tmo, DC);
    end
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      errors++;
      $display("FAIL div0_hilo: hi=%h lo=%h, want 1234/5678", hi, lo);
    end
  endtask

  task automatic test_ignore_and_abort();
    int bc, dc;
    bc = 0; dc = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    if (busy) bc++;
    start = 1'b1; op = 3'd2; a = 32'd50; b = 32'd4; hi_we = 1'b1; wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) dc++;
      if (!busy) break;
      bc++;
      @(negedge clk);
    end
    model_exec(0, 32'd3, 32'd5);
    @(negedge clk);
    checks++;
    if (bc !== MC || dc !== 1 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd15) begin
      errors++;
      $display("FAIL start_mthi_while_busy: cyc=%0d done=%0d busy=%b hi=%h lo=%h, want %0d/1/0/0/f", bc, dc, busy, hi, lo, MC);
    end
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, want 0/0/0/0", busy, done, hi, lo);
    end
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    checks++;
    if (dc !== 0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort_quiet: busy/done samples=%0d lo=%h, want 0/0", dc, lo);
    end
  endtask

  task automatic test_madd();
    int bc, dc; bit held, tmo;
    write_hilo(1'b1, 1'b1, 32'd0);
    write_hilo(1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0, bc, dc, held, tmo);
    model_exec(5, 32'd1, 32'd1);
    checks++;
`ifdef MD_MADD_EN
    if (tmo !== 1'b0 || bc !== MC || dc !== 1 || hi !== 32'd1 || lo !== 32'd0) begin
      errors++;
      $display("FAIL maddu: cyc=%0d done=%0d hi=%h lo=%h, want %0d/1/1/0", bc, dc, hi, lo, MC);
    end
`else
    if (tmo !== 1'b0 || bc !== 0 || dc !== 0 || hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL maddu_illegal: cyc=%0d done=%0d hi=%h lo=%h, want 0/0/0/ffffffff", bc, dc, hi, lo);
    end
`endif
  endtask

  task automatic test_start_vs_mtlo();
    int bc, dc; bit held, tmo;
    write_hilo(1'b0, 1'b1, 32'h55);
    run_op(3'd1, 32'd2, 32'd3, 1'b0, 1'b1, 32'd9, bc, dc, held, tmo);
    model_exec(1, 32'd2, 32'd3);
    checks++;
    if (tmo !== 1'b0 || bc !== MC || dc !== 1 || held !== 1'b1) begin
      errors++;
      $display("FAIL start_vs_mtlo_timing: cyc=%0d done=%0d held=%b, want %0d/1/1", bc, dc, held, MC);
    end
    checks++;
    if (lo !== 32'd6 || hi !== 32'd0) begin
      errors++;
      $display("FAIL start_vs_mtlo_result: hi=%h lo=%h, want 0/6", hi, lo);
    end
  endtask

  task automatic test_random();
    int bc, dc; bit held, tmo;
    for (int i = 0; i < 30; i++) begin
      logic [2:0] o; logic [31:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 9));
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        logic [31:0] wd; bit wh;
        wd = $urandom; wh = 1'($urandom_range(0, 1));
        write_hilo(wh, !wh, wd);
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
          errors++;
          $display("FAIL rand_write: hi=%h lo=%h, want %h/%h", hi, lo, m_hi, m_lo);
        end
      end
      run_op(o, x, y, 1'b0, 1'b0, 32'd0, bc, dc, held, tmo);
      model_exec(int'(o), x, y);
      checks++;
      if (tmo !== 1'b0 || bc !== exp_cycles(int'(o)) || dc !== (legal(int'(o)) ? 1 : 0) || held !== 1'b1) begin
        errors++;
        $display("FAIL rand_timing op=%0d: cyc=%0d done=%0d held=%b timeout=%b, want cyc=%0d", o, bc, dc, held, tmo, exp_cycles(int'(o)));
      end
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL rand_result op=%0d a=%h b=%h: hi=%h lo=%h, want %h/%h", o, x, y, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div0();
    test_ignore_and_abort();
    test_madd();
    test_start_vs_mtlo();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
